fifo_rd_stream: RTL and testbench

- Downstream drain stage for the 32x32 synchronous FIFO.
- Issues FIFO read strobes and captures read data, which arrives one cycle after the strobe.
- Buffers captured words and presents them on a valid/ready stream with packet framing (m_last every PKT_LEN words).
- Decouples FIFO read timing from consumer back-pressure at up to 1 word/cycle.

---
 rtl/fifo_rd_stream_if.sv | 34 +++
 rtl/fifo_rd_stream.sv | 85 ++++++++
 tb/tb_fifo_rd_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read side, output stream and status of the drain stage.
// FIFO_RD_STREAM_STATS_EN adds the stall_cnt/starve_cnt status counters.
interface fifo_rd_stream_if #(parameter int DW = 32);
  logic drain_en;
  logic fifo_empty;
  logic [DW-1:0] fifo_data_op;
  logic fifo_rd_en;
  logic [DW-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  logic [15:0] pkt_cnt;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] starve_cnt;
  modport master (
    input  drain_en, fifo_empty, fifo_data_op, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, pkt_cnt, stall_cnt, starve_cnt
  );
  modport slave (
    output drain_en, fifo_empty, fifo_data_op, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, pkt_cnt, stall_cnt, starve_cnt
  );
`else
  modport master (
    input  drain_en, fifo_empty, fifo_data_op, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, pkt_cnt
  );
  modport slave (
    output drain_en, fifo_empty, fifo_data_op, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, pkt_cnt
  );
`endif
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-output FIFO into a framed valid/ready stream.
// FIFO_RD_STREAM_STATS_EN adds saturating stall and starve cycle counters.
module fifo_rd_stream #(
  parameter int DW         = 32,
  parameter int PKT_LEN    = 8,
  parameter int OBUF_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fifo_rd_stream_if.master bus
);
  localparam int AW = OBUF_DEPTH > 1 ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [CW:0] OCC_LIM = (CW+1)'(OBUF_DEPTH - 1);
  localparam logic [AW-1:0] PTR_MAX = AW'(OBUF_DEPTH - 1);
  localparam logic [15:0] IDX_LAST = 16'(PKT_LEN - 1);

  logic [DW-1:0] buf_q [OBUF_DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic inflight_q;
  logic [15:0] idx_q, idx_d;
  logic [15:0] pkt_q, pkt_d;
  logic [CW:0] occ;
  logic rd_en, valid, pop, last;

  // Words already strobed but not yet captured still reserve a buffer slot.
  always_comb begin
    occ    = {1'b0, cnt_q} + (CW+1)'(inflight_q);
    rd_en  = rst && bus.drain_en && !bus.fifo_empty &&
             (occ < OCC_LIM || (occ == OCC_LIM && !inflight_q));
    valid  = cnt_q != '0;
    pop    = valid && bus.m_ready;
    last   = valid && idx_q == IDX_LAST;
    head_d = pop ? (head_q == PTR_MAX ? '0 : head_q + 1'b1) : head_q;
    tail_d = inflight_q ? (tail_q == PTR_MAX ? '0 : tail_q + 1'b1) : tail_q;
    cnt_d  = cnt_q + CW'(inflight_q) - CW'(pop);
    idx_d  = pop ? (last ? '0 : idx_q + 16'd1) : idx_q;
    pkt_d  = (pop && last) ? pkt_q + 16'd1 : pkt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) buf_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
      pkt_q      <= '0;
    end else begin
      if (inflight_q) buf_q[tail_q] <= bus.fifo_data_op;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd_en;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = buf_q[head_q];
  assign bus.m_last     = last;
  assign bus.pkt_cnt    = pkt_q;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stall_q, starve_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (valid && !bus.m_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (bus.drain_en && bus.fifo_empty && !valid && starve_q != '1) starve_q <= starve_q + 32'd1;
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.starve_cnt = starve_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed bench with a queue-based FIFO/stream model.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int PL = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DW(DW)) bus ();
  fifo_rd_stream_if #(.DW(DW)) bus1 ();

  fifo_rd_stream #(.DW(DW), .PKT_LEN(PL), .OBUF_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  fifo_rd_stream #(.DW(DW), .PKT_LEN(1), .OBUF_DEPTH(D)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.drain_en     = bus.drain_en;
  assign bus1.fifo_empty   = bus.fifo_empty;
  assign bus1.fifo_data_op = bus.fifo_data_op;
  assign bus1.m_ready      = bus.m_ready;

  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  bit inflight_m;
  int idx_m, pkts_m, pkts1_m;
  longint stall_m, starve_m;
  int errs, checks, dut_hs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) src.push_back(base + DW'(i));
  endtask

  task automatic step();
    int buffered, occ;
    bit exp_v, exp_rd, hs, rd_dut;
    logic [DW-1:0] word;
    bus.fifo_empty = src.size() == 0;
    @(negedge clk);
    occ      = exp_q.size();
    buffered = occ - int'(inflight_m);
    exp_v    = buffered > 0;
    exp_rd   = rst && bus.drain_en && src.size() > 0 &&
               (occ < D - 1 || (occ == D - 1 && !inflight_m));
    check("rd_en", bus.fifo_rd_en, exp_rd);
    check("m_valid", bus.m_valid, exp_v);
    if (exp_v) check("m_data", bus.m_data, exp_q[0]);
    check("m_last", bus.m_last, exp_v && idx_m == PL - 1);
    check("pkt_cnt", bus.pkt_cnt, 16'(pkts_m));
    check("m_last_pl1", bus1.m_last, exp_v);
    check("pkt_cnt_pl1", bus1.pkt_cnt, 16'(pkts1_m));
`ifdef FIFO_RD_STREAM_STATS_EN
    check("stall_cnt", bus.stall_cnt, stall_m);
    check("starve_cnt", bus.starve_cnt, starve_m);
`endif
    hs     = exp_v && bus.m_ready;
    rd_dut = bus.fifo_rd_en;
    dut_hs += int'(bus.m_valid && bus.m_ready);
    word   = src.size() > 0 ? src[0] : '0;
    @(posedge clk);
    #1;
    if (rd_dut && src.size() > 0) bus.fifo_data_op = src.pop_front();
    if (!rst) begin
      exp_q.delete();
      inflight_m = 0;
      idx_m = 0;
      pkts_m = 0;
      pkts1_m = 0;
      stall_m = 0;
      starve_m = 0;
    end else begin
      if (exp_v && !bus.m_ready) stall_m++;
      if (bus.drain_en && src.size() + int'(rd_dut) == 0 && buffered == 0) starve_m++;
      if (hs) begin
        void'(exp_q.pop_front());
        pkts1_m = (pkts1_m + 1) % 65536;
        if (idx_m == PL - 1) begin
          idx_m = 0;
          pkts_m = (pkts_m + 1) % 65536;
        end else idx_m++;
      end
      if (exp_rd) exp_q.push_back(word);
      inflight_m = exp_rd;
    end
  endtask

  initial begin
    int hs0;
    bit found;
    bus.drain_en = 1'b1;
    bus.m_ready = 1'b1;
    bus.fifo_data_op = '0;
    bus.fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    load(16, 32'h100);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    hs0 = dut_hs;
    for (int i = 0; i < 18; i++) step();
    check("stream_hs", 64'(dut_hs - hs0), 16);
    check("stream_pkts", bus.pkt_cnt, 2);

    load(20, 32'h200);
    hs0 = dut_hs;
    for (int i = 0; i < 4; i++) step();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("bp_hs", 64'(dut_hs - hs0), 20);

    load(6, 32'h300);
    hs0 = dut_hs;
    step();
    bus.drain_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("drop_hs", 64'(dut_hs - hs0), 1);
    bus.drain_en = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("drop_rest", 64'(dut_hs - hs0), 6);

    load(8, 32'h400);
    bus.m_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = exp_q.size() == 3 && inflight_m;
    end
    check("rst_mid_setup", found, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    for (int n = 0; n < 3000; n++) begin
      bus.m_ready  = $urandom_range(0, 3) != 0;
      bus.drain_en = $urandom_range(0, 7) != 0;
      rst = $urandom_range(0, 399) != 0;
      if (src.size() < 3 && $urandom_range(0, 3) == 0)
        load($urandom_range(1, 12), DW'($urandom));
      step();
    end
    rst = 1'b1;
    bus.m_ready = 1'b1;
    bus.drain_en = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("final_drain", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
